alu_result_checker: RTL

//  Synthesizable response checker at the output side of the ALU. It samples the operands and opcode

---
 rtl/alu_result_checker.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_result_checker.sv
`default_nettype none
// ============================================================================
//  Module   : alu_result_checker
//  Purpose  : Response checker placed at the output side of the ALU. It
//             samples the operands and opcode driven into the ALU, recomputes
//             the expected result (and, optionally, the flags), carries them
//             through a LATENCY-deep delay line and compares them against the
//             ALU outputs when they arrive. It reports a per-vector
//             pass/fail pulse, keeps saturating compare and error counters,
//             and captures the first failing vector.
//  Ports    : clock, reset          - rising-edge clock, synchronous active-high reset
//             enable, A, B, control - stimulus driven into the ALU this cycle
//             result, overflow,
//             negative, zero        - ALU outputs, LATENCY cycles after stimulus
//             check_valid, mismatch - registered compare pulse / failure flag
//             check_count,
//             error_count           - saturating compare / mismatch counters
//             first_fail            - {control, A, B} of the first failing vector
//             halted                - checker frozen after a mismatch (STOP_ON_ERROR)
//  Config   : ALU_CHECKER_FLAGS_EN  - when defined, overflow/negative/zero are
//                                     compared as well as result; otherwise the
//                                     flag inputs are ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_result_checker #(
    parameter int LENGTH_v      = 5,
    parameter int LATENCY       = 1,
    parameter int STOP_ON_ERROR = 0,
    parameter int CNT_W         = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [LENGTH_v-1:0]     A,
    input  logic [LENGTH_v-1:0]     B,
    input  logic [3:0]              control,
    input  logic [2*LENGTH_v-1:0]   result,
    input  logic                    overflow,
    input  logic                    negative,
    input  logic                    zero,
    output logic                    check_valid,
    output logic                    mismatch,
    output logic [CNT_W-1:0]        check_count,
    output logic [CNT_W-1:0]        error_count,
    output logic [4+2*LENGTH_v-1:0] first_fail,
    output logic                    halted
);

    localparam int          c_RW      = 2 * LENGTH_v;
    localparam int          c_TAIL    = LATENCY - 1;
    localparam bit          c_STOP    = (STOP_ON_ERROR != 0);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_CHECK = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic [2:0] r_fill_cnt;
    logic [2:0] w_fill_cnt_nxt;

    // ------------------------------------------------------------------
    // Expected-value model
    // ------------------------------------------------------------------
    logic [c_RW-1:0] w_a_ext;
    logic [c_RW-1:0] w_b_ext;
    logic [c_RW-1:0] w_exp;

    assign w_a_ext = {{LENGTH_v{1'b0}}, A};
    assign w_b_ext = {{LENGTH_v{1'b0}}, B};

    always_comb begin
        w_exp = '0;
        case (control)
            4'd0:    w_exp = w_a_ext + w_b_ext;
            4'd1:    w_exp = w_a_ext - w_b_ext;
            4'd2:    w_exp = w_a_ext * w_b_ext;
            4'd3:    w_exp = w_a_ext & w_b_ext;
            4'd4:    w_exp = w_a_ext | w_b_ext;
            4'd5:    w_exp = w_a_ext ^ w_b_ext;
            4'd6:    w_exp = {{LENGTH_v{1'b0}}, ~A};
            4'd7:    w_exp = w_a_ext << 1;
            4'd8:    w_exp = w_a_ext >> 1;
            4'd9:    w_exp = w_b_ext;
            default: w_exp = '0;
        endcase
    end

`ifdef ALU_CHECKER_FLAGS_EN
    // Overflow is judged on the operands as LENGTH_v-bit signed values,
    // independent of the zero-extended 2*LENGTH_v result.
    logic [LENGTH_v-1:0] w_sum_n;
    logic [LENGTH_v-1:0] w_dif_n;
    logic                w_exp_ovf;
    logic [2:0]          w_exp_flg;

    assign w_sum_n = A + B;
    assign w_dif_n = A - B;

    always_comb begin
        w_exp_ovf = 1'b0;
        case (control)
            4'd0:    w_exp_ovf = (A[LENGTH_v-1] == B[LENGTH_v-1]) &&
                                 (w_sum_n[LENGTH_v-1] != A[LENGTH_v-1]);
            4'd1:    w_exp_ovf = (A[LENGTH_v-1] != B[LENGTH_v-1]) &&
                                 (w_dif_n[LENGTH_v-1] != A[LENGTH_v-1]);
            default: w_exp_ovf = 1'b0;
        endcase
    end

    assign w_exp_flg = {w_exp_ovf, w_exp[c_RW-1], (w_exp == '0)};
`endif

    // ------------------------------------------------------------------
    // Delay line: one stage per ALU pipeline cycle, shifted every cycle.
    // Bubbles (enable=0) travel through like any other entry.
    // ------------------------------------------------------------------
    logic                r_dl_vld [LATENCY];
    logic [3:0]          r_dl_ctl [LATENCY];
    logic [LENGTH_v-1:0] r_dl_a   [LATENCY];
    logic [LENGTH_v-1:0] r_dl_b   [LATENCY];
    logic [c_RW-1:0]     r_dl_exp [LATENCY];
`ifdef ALU_CHECKER_FLAGS_EN
    logic [2:0]          r_dl_flg [LATENCY];
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_dl_vld[i] <= 1'b0;
                r_dl_ctl[i] <= '0;
                r_dl_a[i]   <= '0;
                r_dl_b[i]   <= '0;
                r_dl_exp[i] <= '0;
`ifdef ALU_CHECKER_FLAGS_EN
                r_dl_flg[i] <= '0;
`endif
            end
        end else begin
            r_dl_vld[0] <= enable;
            r_dl_ctl[0] <= control;
            r_dl_a[0]   <= A;
            r_dl_b[0]   <= B;
            r_dl_exp[0] <= w_exp;
`ifdef ALU_CHECKER_FLAGS_EN
            r_dl_flg[0] <= w_exp_flg;
`endif
            for (int i = 1; i < LATENCY; i++) begin
                r_dl_vld[i] <= r_dl_vld[i-1];
                r_dl_ctl[i] <= r_dl_ctl[i-1];
                r_dl_a[i]   <= r_dl_a[i-1];
                r_dl_b[i]   <= r_dl_b[i-1];
                r_dl_exp[i] <= r_dl_exp[i-1];
`ifdef ALU_CHECKER_FLAGS_EN
                r_dl_flg[i] <= r_dl_flg[i-1];
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Compare at the tail of the delay line
    // ------------------------------------------------------------------
    logic w_mis;
    logic w_do_cmp;

`ifdef ALU_CHECKER_FLAGS_EN
    assign w_mis = (result != r_dl_exp[c_TAIL]) ||
                   ({overflow, negative, zero} != r_dl_flg[c_TAIL]);
`else
    logic w_unused_flags;
    assign w_unused_flags = overflow ^ negative ^ zero;
    assign w_mis = (result != r_dl_exp[c_TAIL]);
`endif

    // The first vector reaches the tail on the last FILL cycle; its compare
    // result is registered as FILL hands over to CHECK, so check_valid is
    // never seen high before CHECK.
    assign w_do_cmp = r_dl_vld[c_TAIL] && ((r_state == S_FILL) || (r_state == S_CHECK));

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_fill_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fill_cnt <= w_fill_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fill_cnt_nxt = r_fill_cnt;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt    = S_FILL;
                    w_fill_cnt_nxt = '0;
                end
            end
            S_FILL: begin
                if (c_STOP && w_do_cmp && w_mis) begin
                    w_state_nxt = S_HALT;
                end else if (r_fill_cnt == 3'(LATENCY - 1)) begin
                    w_state_nxt = S_CHECK;
                end else begin
                    w_fill_cnt_nxt = r_fill_cnt + 3'd1;
                end
            end
            S_CHECK: begin
                if (c_STOP && w_do_cmp && w_mis) begin
                    w_state_nxt = S_HALT;
                end
            end
            default: w_state_nxt = S_HALT;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered result outputs; everything freezes once halted.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            check_valid <= 1'b0;
            mismatch    <= 1'b0;
            check_count <= '0;
            error_count <= '0;
            first_fail  <= '0;
            halted      <= 1'b0;
        end else if (r_state != S_HALT) begin
            check_valid <= w_do_cmp;
            mismatch    <= w_do_cmp && w_mis;
            halted      <= (w_state_nxt == S_HALT);
            if (w_do_cmp && (check_count != c_CNT_MAX)) begin
                check_count <= check_count + CNT_W'(1);
            end
            if (w_do_cmp && w_mis) begin
                if (error_count != c_CNT_MAX) begin
                    error_count <= error_count + CNT_W'(1);
                end
                if (error_count == '0) begin
                    first_fail <= {r_dl_ctl[c_TAIL], r_dl_a[c_TAIL], r_dl_b[c_TAIL]};
                end
            end
        end
    end

endmodule
`default_nettype wire
